// File: rtl/pwm_capture.sv
// PWM capture: measures high time and rise-to-rise period of an asynchronous
// PWM input and publishes them with a one-cycle valid strobe. A stuck input
// (no edge for TIMEOUT cycles) is published as a stuck result, with the duty
// cycle reflecting the stuck level.
module pwm_capture #(
  parameter int PWM_INTERVAL = 1200,
  parameter int TIMEOUT      = 2 * PWM_INTERVAL
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                pwm_in,
  output logic [$clog2(PWM_INTERVAL+1)-1:0]   duty_cycle,
  output logic [$clog2(TIMEOUT+1)-1:0]        period,
  output logic                                valid,
  output logic                                stuck
);

  localparam int DW = $clog2(PWM_INTERVAL + 1);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;

  localparam logic [CW-1:0] CLAMP    = CW'(PWM_INTERVAL);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [DW-1:0] DUTY_MAX = DW'(PWM_INTERVAL);

  logic [1:0]    sync_q, sync_d;
  logic          d_q, d_d;
  logic [2:0]    fill_q, fill_d;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] high_cnt_q, high_cnt_d;
  logic [CW-1:0] per_cnt_q, per_cnt_d;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic [DW-1:0] duty_q, duty_d;
  logic [CW-1:0] period_q, period_d;
  logic          valid_q, valid_d;
  logic          stuck_q, stuck_d;

  logic s2;
  logic rise;
  logic fall;
  logic any_edge;
  logic timeout_hit;

  // Counters stop at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // The synchronizer and delayed copy restart from 0 after reset, so a level
  // that was already high would look like a rise. Edges are only trusted once
  // both synchronizer stages and the delayed copy hold real samples (fill_q[2]).
  assign s2          = sync_q[1];
  assign rise        = fill_q[2] & s2 & ~d_q;
  assign fall        = fill_q[2] & ~s2 & d_q;
  assign any_edge    = rise | fall;
  assign timeout_hit = ~any_edge & (idle_cnt_q == TO_LAST);

  // Next-state logic: edge detection, measurement FSM, timeout and publish.
  always_comb begin
    sync_d     = {sync_q[0], pwm_in};
    d_d        = s2;
    fill_d     = {fill_q[1:0], 1'b1};
    state_d    = state_q;
    high_cnt_d = high_cnt_q;
    per_cnt_d  = per_cnt_q;
    idle_cnt_d = any_edge ? '0 : sat_inc(idle_cnt_q);
    duty_d     = duty_q;
    period_d   = period_q;
    valid_d    = 1'b0;
    stuck_d    = stuck_q;

    case (state_q)
      S_IDLE: begin
        // First rise only starts a measurement; nothing is published yet.
        if (rise) begin
          high_cnt_d = CW'(1);
          per_cnt_d  = CW'(1);
          state_d    = S_HIGH;
        end
      end
      S_HIGH: begin
        per_cnt_d = sat_inc(per_cnt_q);
        if (fall) begin
          state_d = S_LOW;
        end else begin
          high_cnt_d = sat_inc(high_cnt_q);
        end
      end
      S_LOW: begin
        if (rise) begin
          duty_d     = (high_cnt_q > CLAMP) ? DUTY_MAX : high_cnt_q[DW-1:0];
          period_d   = per_cnt_q;
          stuck_d    = 1'b0;
          valid_d    = 1'b1;
          high_cnt_d = CW'(1);
          per_cnt_d  = CW'(1);
          state_d    = S_HIGH;
        end else begin
          per_cnt_d = sat_inc(per_cnt_q);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // No edge for TIMEOUT cycles: report the stuck level and restart from IDLE.
    if (timeout_hit) begin
      duty_d     = s2 ? DUTY_MAX : '0;
      period_d   = '0;
      stuck_d    = 1'b1;
      valid_d    = 1'b1;
      idle_cnt_d = '0;
      state_d    = S_IDLE;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      d_q        <= 1'b0;
      fill_q     <= '0;
      state_q    <= S_IDLE;
      high_cnt_q <= '0;
      per_cnt_q  <= '0;
      idle_cnt_q <= '0;
      duty_q     <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      stuck_q    <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      d_q        <= d_d;
      fill_q     <= fill_d;
      state_q    <= state_d;
      high_cnt_q <= high_cnt_d;
      per_cnt_q  <= per_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      duty_q     <= duty_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      stuck_q    <= stuck_d;
    end
  end

  assign duty_cycle = duty_q;
  assign period     = period_q;
  assign valid      = valid_q;
  assign stuck      = stuck_q;

endmodule
